// File: rtl/ro_frame_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : ro_frame_scheduler
//  Purpose  : Frame-level sequencer in the ADC_CLK domain. Runs a burst of
//             exposure/readout cycles, hands each frame to the row-readout
//             FSM via FSMIND1/FSMIND1ACK, collects completion on
//             FSMIND0/FSMIND0ACK, checks the per-frame row count and guards
//             the readout handshake with a watchdog.
//  Revision : 1.0 - initial release
// ============================================================================
module ro_frame_scheduler #(
  parameter int unsigned C_NUM_ROWS  = 160,
  parameter int unsigned TIMEOUT_CYC = 65536,
  parameter int unsigned DRAIN_CYC   = 32,
  parameter int unsigned ACK_HOLD    = 4
) (
  input  logic        ADC_CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic        STOP,
  input  logic [15:0] NUM_FRAMES,
  output logic        EXP_START,
  input  logic        EXP_DONE,
  output logic        FSMIND1,
  input  logic        FSMIND1ACK,
  input  logic        FSMIND0,
  output logic        FSMIND0ACK,
  input  logic        ADC_DATA_VALID,
  output logic        BUSY,
  output logic [15:0] FRAME_CNT,
  output logic        FRAME_DONE,
  output logic        ERR_TIMEOUT,
  output logic        ERR_ROWCNT
);

  localparam int unsigned C_WD_W    = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned C_DR_W    = $clog2(DRAIN_CYC + 1);
  localparam int unsigned C_AH_W    = $clog2(ACK_HOLD + 1);
  localparam logic [C_WD_W-1:0] C_WD_LAST    = C_WD_W'(TIMEOUT_CYC - 1);
  localparam logic [C_DR_W-1:0] C_DRAIN_LAST = C_DR_W'(DRAIN_CYC - 1);
  localparam logic [C_AH_W-1:0] C_HOLD_LAST  = C_AH_W'(ACK_HOLD - 1);
  localparam logic [15:0]       C_ROWS16     = 16'(C_NUM_ROWS);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_EXPOSE    = 3'd1,
    S_REQ       = 3'd2,
    S_READOUT   = 3'd3,
    S_DONE_ACK  = 3'd4,
    S_DRAIN     = 3'd5,
    S_FRAME_END = 3'd6
  } state_t;

  state_t              r_state;
  logic                r_exp_done_q;
  logic                r_ack1_q;
  logic                r_ind0_q;
  logic                r_valid_q;
  logic                r_valid_prev;
  logic [15:0]         r_num_frames;
  logic                r_stop_pending;
  logic [C_WD_W-1:0]   r_wd;
  logic [C_AH_W-1:0]   r_hold;
  logic [C_DR_W-1:0]   r_drain;
  logic [15:0]         r_rows;

  logic                w_valid_rise;
  logic [15:0]         w_rows_next;
  logic                w_stop_req;

  // One-register input sampling; the pixel clock is synchronous to ADC_CLK.
  always_ff @(posedge ADC_CLK) begin
    if (RESET) begin
      r_exp_done_q <= 1'b0;
      r_ack1_q     <= 1'b0;
      r_ind0_q     <= 1'b1;
      r_valid_q    <= 1'b0;
      r_valid_prev <= 1'b0;
    end else begin
      r_exp_done_q <= EXP_DONE;
      r_ack1_q     <= FSMIND1ACK;
      r_ind0_q     <= FSMIND0;
      r_valid_q    <= ADC_DATA_VALID;
      r_valid_prev <= r_valid_q;
    end
  end

  // Row-edge detection, saturating row count and stop request decode.
  always_comb begin
    w_valid_rise = r_valid_q & ~r_valid_prev;
    w_rows_next  = (w_valid_rise && (r_rows != 16'hFFFF)) ? r_rows + 16'd1 : r_rows;
    w_stop_req   = STOP | r_stop_pending;
  end

  // Frame sequencer with registered outputs, watchdog and row check.
  always_ff @(posedge ADC_CLK) begin
    if (RESET) begin
      r_state        <= S_IDLE;
      r_num_frames   <= '0;
      r_stop_pending <= 1'b0;
      r_wd           <= '0;
      r_hold         <= '0;
      r_drain        <= '0;
      r_rows         <= '0;
      EXP_START      <= 1'b0;
      FSMIND1        <= 1'b0;
      FSMIND0ACK     <= 1'b0;
      BUSY           <= 1'b0;
      FRAME_CNT      <= '0;
      FRAME_DONE     <= 1'b0;
      ERR_TIMEOUT    <= 1'b0;
      ERR_ROWCNT     <= 1'b0;
    end else begin
      EXP_START  <= 1'b0;
      FRAME_DONE <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (START && !STOP) begin
            r_num_frames   <= NUM_FRAMES;
            FRAME_CNT      <= '0;
            ERR_TIMEOUT    <= 1'b0;
            ERR_ROWCNT     <= 1'b0;
            r_stop_pending <= 1'b0;
            EXP_START      <= 1'b1;
            BUSY           <= 1'b1;
            r_state        <= S_EXPOSE;
          end
        end
        S_EXPOSE: begin
          if (w_stop_req) begin
            r_stop_pending <= 1'b0;
            BUSY           <= 1'b0;
            r_state        <= S_IDLE;
          end else if (r_exp_done_q) begin
            r_wd    <= '0;
            FSMIND1 <= 1'b1;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (STOP) r_stop_pending <= 1'b1;
          if (r_wd == C_WD_LAST) begin
            ERR_TIMEOUT <= 1'b1;
            FSMIND1     <= 1'b0;
            BUSY        <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_wd <= r_wd + C_WD_W'(1);
            if (r_ack1_q) begin
              FSMIND1 <= 1'b0;
              r_rows  <= '0;
              r_state <= S_READOUT;
            end
          end
        end
        S_READOUT: begin
          if (STOP) r_stop_pending <= 1'b1;
          r_rows <= w_rows_next;
          if (r_wd == C_WD_LAST) begin
            ERR_TIMEOUT <= 1'b1;
            FSMIND0ACK  <= 1'b0;
            BUSY        <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_wd <= r_wd + C_WD_W'(1);
            if (r_ind0_q) begin
              FSMIND0ACK <= 1'b1;
              r_hold     <= '0;
              r_state    <= S_DONE_ACK;
            end
          end
        end
        S_DONE_ACK: begin
          if (STOP) r_stop_pending <= 1'b1;
          r_rows <= w_rows_next;
          if (r_hold == C_HOLD_LAST) begin
            FSMIND0ACK <= 1'b0;
            r_drain    <= '0;
            r_state    <= S_DRAIN;
          end else begin
            r_hold <= r_hold + C_AH_W'(1);
          end
        end
        S_DRAIN: begin
          if (STOP) r_stop_pending <= 1'b1;
          r_rows <= w_rows_next;
          if (r_drain == C_DRAIN_LAST) begin
            if (w_rows_next != C_ROWS16) ERR_ROWCNT <= 1'b1;
            FRAME_DONE <= 1'b1;
            FRAME_CNT  <= FRAME_CNT + 16'd1;
            r_state    <= S_FRAME_END;
          end else begin
            r_drain <= r_drain + C_DR_W'(1);
          end
        end
        S_FRAME_END: begin
          if (w_stop_req || ((r_num_frames != 16'd0) && (FRAME_CNT == r_num_frames))) begin
            r_stop_pending <= 1'b0;
            BUSY           <= 1'b0;
            r_state        <= S_IDLE;
          end else begin
            EXP_START <= 1'b1;
            r_state   <= S_EXPOSE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
